// File: rtl/axi_slv_rd_ctrl_pkg.sv
// Shared AXI widths, burst/response/size encodings for the AXI read-channel SRAM responder.
package axi_slv_rd_ctrl_pkg;

    localparam int AXI_ID_WIDTH    = 4;
    localparam int AXI_ADDR_WIDTH  = 32;
    localparam int AXI_LEN_WIDTH   = 8;
    localparam int AXI_SIZE_WIDTH  = 3;
    localparam int AXI_BURST_WIDTH = 2;
    localparam int AXI_DATA_WIDTH  = 32;
    localparam int AXI_RESP_WIDTH  = 2;

    localparam logic [AXI_BURST_WIDTH-1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [AXI_BURST_WIDTH-1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [AXI_BURST_WIDTH-1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_SLVERR = 2'b10;

    localparam logic [AXI_SIZE_WIDTH-1:0] AXI_SIZE_4_BYTE = 3'd2;

endpackage

// File: rtl/axi_slv_rd_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts; burst code 2'b11 behaves as INCR.
module axi_slv_rd_addr_gen
    import axi_slv_rd_ctrl_pkg::*;
(
    input  logic [AXI_ADDR_WIDTH-1:0]  i_addr,
    input  logic [AXI_SIZE_WIDTH-1:0]  i_size,
    input  logic [AXI_LEN_WIDTH-1:0]   i_len,
    input  logic [AXI_BURST_WIDTH-1:0] i_burst,
    output logic [AXI_ADDR_WIDTH-1:0]  o_next_addr
);

    logic [AXI_ADDR_WIDTH-1:0] w_incr;
    logic [AXI_ADDR_WIDTH-1:0] w_mask;

    always_comb begin
        w_incr = 32'd1 << i_size;
        // Wrap window is the whole burst: (len+1) beats of 2^size bytes.
        w_mask = (({24'd0, i_len} + 32'd1) << i_size) - 32'd1;
        case (i_burst)
            AXI_BURST_FIXED: o_next_addr = i_addr;
            AXI_BURST_WRAP:  o_next_addr = (i_addr & ~w_mask) | ((i_addr + w_incr) & w_mask);
            default:         o_next_addr = (i_addr & ~(w_incr - 32'd1)) + w_incr;
        endcase
    end

endmodule

// File: rtl/axi_slv_rd_ctrl.sv
// AXI4 read-channel responder in front of a single-port synchronous SRAM (one AR at a time).
// Optional beat error checking is enabled by defining AXI_SLV_RD_ERR_CHK_EN.
module axi_slv_rd_ctrl
    import axi_slv_rd_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          MEM_ADDR_WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       axi_slv_arvalid,
    output logic                       axi_slv_arready,
    input  logic [AXI_ID_WIDTH-1:0]    axi_slv_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]  axi_slv_araddr,
    input  logic [AXI_LEN_WIDTH-1:0]   axi_slv_arlen,
    input  logic [AXI_SIZE_WIDTH-1:0]  axi_slv_arsize,
    input  logic [AXI_BURST_WIDTH-1:0] axi_slv_arburst,
    output logic                       axi_slv_rvalid,
    input  logic                       axi_slv_rready,
    output logic [AXI_ID_WIDTH-1:0]    axi_slv_rid,
    output logic [AXI_DATA_WIDTH-1:0]  axi_slv_rdata,
    output logic [AXI_RESP_WIDTH-1:0]  axi_slv_rresp,
    output logic                       axi_slv_rlast,
    output logic                       mem_rd_en,
    output logic [MEM_ADDR_WIDTH-1:0]  mem_rd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]  mem_rd_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic                       r_rst_done;
    logic [AXI_ID_WIDTH-1:0]    r_id;
    logic [AXI_ADDR_WIDTH-1:0]  r_addr;
    logic [AXI_LEN_WIDTH-1:0]   r_len;
    logic [AXI_SIZE_WIDTH-1:0]  r_size;
    logic [AXI_BURST_WIDTH-1:0] r_burst;
    logic [AXI_LEN_WIDTH-1:0]   r_beat_cnt;
    logic [AXI_DATA_WIDTH-1:0]  r_rdata;
    logic                       r_hold;

    logic                       w_arready;
    logic                       w_ar_hs;
    logic                       w_last;
    logic                       w_beat_err;
    logic [AXI_ADDR_WIDTH-1:0]  w_next_addr;
    logic [MEM_ADDR_WIDTH-1:0]  w_word_addr;

    axi_slv_rd_addr_gen u_addr_gen (
        .i_addr      (r_addr),
        .i_size      (r_size),
        .i_len       (r_len),
        .i_burst     (r_burst),
        .o_next_addr (w_next_addr)
    );

`ifdef AXI_SLV_RD_ERR_CHK_EN
    localparam logic [32:0] MEM_BYTES = 33'd4 << MEM_ADDR_WIDTH;

    logic w_range_err;
    logic w_cmd_err;

    // A start below BASE_ADDR wraps the 33-bit difference far above MEM_BYTES.
    assign w_range_err = (({1'b0, r_addr} - {1'b0, BASE_ADDR}) >= MEM_BYTES);
    assign w_cmd_err   = (r_size > AXI_SIZE_4_BYTE) || (r_burst == 2'b11) ||
                         ((r_burst == AXI_BURST_WRAP) &&
                          !((r_len == 8'd1) || (r_len == 8'd3) || (r_len == 8'd7) || (r_len == 8'd15)));
    assign w_beat_err  = w_range_err || w_cmd_err;
`else
    assign w_beat_err  = 1'b0;
`endif

    assign w_word_addr = MEM_ADDR_WIDTH'((r_addr - BASE_ADDR) >> 2);
    assign w_arready   = (r_state == S_IDLE) && r_rst_done;
    assign w_ar_hs     = axi_slv_arvalid && w_arready;
    assign w_last      = (r_beat_cnt == r_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_ar_hs) w_state_nxt = S_MEM;
            S_MEM:  w_state_nxt = S_DATA;
            S_DATA: if (axi_slv_rready) w_state_nxt = w_last ? S_IDLE : S_MEM;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // SRAM data arrives in the first DATA cycle; it is passed through then and held in r_rdata while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_done <= 1'b0;
            r_id       <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_size     <= '0;
            r_burst    <= '0;
            r_beat_cnt <= '0;
            r_rdata    <= '0;
            r_hold     <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
            if (w_ar_hs) begin
                r_id       <= axi_slv_arid;
                r_addr     <= axi_slv_araddr;
                r_len      <= axi_slv_arlen;
                r_size     <= axi_slv_arsize;
                r_burst    <= axi_slv_arburst;
                r_beat_cnt <= '0;
            end
            if (r_state == S_DATA) begin
                if (axi_slv_rready) begin
                    r_hold <= 1'b0;
                    if (!w_last) begin
                        r_addr     <= w_next_addr;
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                    end
                end else if (!r_hold) begin
                    r_hold  <= 1'b1;
                    r_rdata <= mem_rd_data;
                end
            end
        end
    end

    assign axi_slv_arready = w_arready;
    assign axi_slv_rvalid  = (r_state == S_DATA);
    assign axi_slv_rlast   = axi_slv_rvalid && w_last;
    assign axi_slv_rid     = r_id;
    assign axi_slv_rresp   = (axi_slv_rvalid && w_beat_err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign axi_slv_rdata   = (!axi_slv_rvalid || w_beat_err) ? '0 : (r_hold ? r_rdata : mem_rd_data);
    assign mem_rd_en       = (r_state == S_MEM) && !w_beat_err;
    assign mem_rd_addr     = mem_rd_en ? w_word_addr : '0;

endmodule

// File: tb/tb_axi_slv_rd_ctrl.sv
// Scoreboard bench for axi_slv_rd_ctrl: directed and random bursts against a burst-address reference model.
module tb_axi_slv_rd_ctrl;
  import axi_slv_rd_ctrl_pkg::*;

  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam int          MAW       = 12;
  localparam int          MEM_WORDS = 1 << MAW;

  logic        clk;
  logic        rst_n;
  logic        axi_slv_arvalid;
  logic        axi_slv_arready;
  logic [3:0]  axi_slv_arid;
  logic [31:0] axi_slv_araddr;
  logic [7:0]  axi_slv_arlen;
  logic [2:0]  axi_slv_arsize;
  logic [1:0]  axi_slv_arburst;
  logic        axi_slv_rvalid;
  logic        axi_slv_rready;
  logic [3:0]  axi_slv_rid;
  logic [31:0] axi_slv_rdata;
  logic [1:0]  axi_slv_rresp;
  logic        axi_slv_rlast;
  logic        mem_rd_en;
  logic [11:0] mem_rd_addr;
  logic [31:0] mem_rd_data;

  logic [31:0] mem [0:MEM_WORDS-1];

  // expected beat: {id[38:35], resp[34:33], last[32], data[31:0]}
  logic [38:0] exp_q[$];
  logic [11:0] exp_addr_q[$];
  logic [38:0] mon_beat;
  logic [11:0] mon_addr;
  int          total;
  int          bad;
  bit          rr_manual;

  axi_slv_rd_ctrl #(
    .BASE_ADDR      (BASE),
    .MEM_ADDR_WIDTH (MAW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .axi_slv_arvalid (axi_slv_arvalid),
    .axi_slv_arready (axi_slv_arready),
    .axi_slv_arid    (axi_slv_arid),
    .axi_slv_araddr  (axi_slv_araddr),
    .axi_slv_arlen   (axi_slv_arlen),
    .axi_slv_arsize  (axi_slv_arsize),
    .axi_slv_arburst (axi_slv_arburst),
    .axi_slv_rvalid  (axi_slv_rvalid),
    .axi_slv_rready  (axi_slv_rready),
    .axi_slv_rid     (axi_slv_rid),
    .axi_slv_rdata   (axi_slv_rdata),
    .axi_slv_rresp   (axi_slv_rresp),
    .axi_slv_rlast   (axi_slv_rlast),
    .mem_rd_en       (mem_rd_en),
    .mem_rd_addr     (mem_rd_addr),
    .mem_rd_data     (mem_rd_data)
  );

  // ---------------- clock / reset / memory model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: beat addresses from burst rules, data from the memory image.
  task automatic gen_expect(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    longint unsigned bytes, win, lower, a, start;
    logic            err;
    logic [11:0]     word;
    start = longint'(addr);
    bytes = longint'(1) << size;
    for (int i = 0; i <= int'(len); i++) begin
      case (burst)
        AXI_BURST_FIXED: a = start;
        AXI_BURST_WRAP: begin
          win   = (longint'(len) + 1) * bytes;
          lower = start - (start % win);
          a     = lower + ((start - lower) + longint'(i) * bytes) % win;
        end
        default: a = (i == 0) ? start : (start / bytes) * bytes + longint'(i) * bytes;
      endcase
      err = 1'b0;
`ifdef AXI_SLV_RD_ERR_CHK_EN
      if (a < longint'(BASE) || a >= longint'(BASE) + 4 * MEM_WORDS) err = 1'b1;
      if (size > 3'd2 || burst == 2'b11) err = 1'b1;
      if (burst == AXI_BURST_WRAP && !(len == 1 || len == 3 || len == 7 || len == 15)) err = 1'b1;
`endif
      word = 12'(((a - longint'(BASE)) >> 2) % MEM_WORDS);
      if (!err) exp_addr_q.push_back(word);
      exp_q.push_back({id, err ? AXI_RESP_SLVERR : AXI_RESP_OKAY, (i == int'(len)), err ? 32'd0 : mem[word]});
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd_en) begin
        if (exp_addr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL mem_rd_unexpected: got read of 0x%0h want no read", mem_rd_addr);
        end else begin
          mon_addr = exp_addr_q.pop_front();
          chk("mem_rd_addr", 64'(mem_rd_addr), 64'(mon_addr));
        end
      end
      if (axi_slv_rvalid && axi_slv_rready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL r_unexpected: got beat data 0x%0h want no beat", axi_slv_rdata);
        end else begin
          mon_beat = exp_q.pop_front();
          chk("rdata", 64'(axi_slv_rdata), 64'(mon_beat[31:0]));
          chk("rlast", 64'(axi_slv_rlast), 64'(mon_beat[32]));
          chk("rresp", 64'(axi_slv_rresp), 64'(mon_beat[34:33]));
          chk("rid",   64'(axi_slv_rid),   64'(mon_beat[38:35]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rr_manual) axi_slv_rready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_arready"}, 64'(axi_slv_arready), 64'd0);
    chk({tag, "_rvalid"},  64'(axi_slv_rvalid),  64'd0);
    chk({tag, "_rlast"},   64'(axi_slv_rlast),   64'd0);
    chk({tag, "_rid"},     64'(axi_slv_rid),     64'd0);
    chk({tag, "_rdata"},   64'(axi_slv_rdata),   64'd0);
    chk({tag, "_rresp"},   64'(axi_slv_rresp),   64'd0);
    chk({tag, "_mem_en"},  64'(mem_rd_en),       64'd0);
    chk({tag, "_mem_adr"}, 64'(mem_rd_addr),     64'd0);
  endtask

  // Issues one AR; returns at the negedge of the cycle carrying the first rvalid.
  task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    bit ok;
    gen_expect(id, addr, len, size, burst);
    @(posedge clk);
    #1;
    axi_slv_arid    = id;
    axi_slv_araddr  = addr;
    axi_slv_arlen   = len;
    axi_slv_arsize  = size;
    axi_slv_arburst = burst;
    axi_slv_arvalid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (axi_slv_arready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ar_handshake", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    axi_slv_arvalid = 1'b0;
    axi_slv_arid    = 4'($urandom);
    axi_slv_araddr  = $urandom;
    if (!ok) return;
    @(negedge clk);
    chk("lat_t1_rvalid",  64'(axi_slv_rvalid),  64'd0);
    chk("lat_t1_arready", 64'(axi_slv_arready), 64'd0);
    @(negedge clk);
    chk("lat_t2_rvalid",  64'(axi_slv_rvalid),  64'd1);
  endtask

  task automatic wait_done();
    for (int c = 0; c < 5000; c++) begin
      if (exp_q.size() == 0 && exp_addr_q.size() == 0) break;
      @(negedge clk);
    end
    chk("burst_beats_left", 64'(exp_q.size()), 64'd0);
    chk("burst_reads_left", 64'(exp_addr_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0]  b;
    logic [7:0]  l;
    logic [2:0]  s;
    logic [31:0] a;
    logic [7:0]  wrap_lens [4];
    wrap_lens[0] = 8'd1; wrap_lens[1] = 8'd3; wrap_lens[2] = 8'd7; wrap_lens[3] = 8'd15;
    total = 0;
    bad   = 0;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    rr_manual       = 1'b1;
    rst_n           = 1'b0;
    axi_slv_rready  = 1'b0;
    axi_slv_arvalid = 1'b0;
    axi_slv_arid    = '0;
    axi_slv_araddr  = '0;
    axi_slv_arlen   = '0;
    axi_slv_arsize  = '0;
    axi_slv_arburst = '0;

    #1;
    chk_all_zero("rst");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("arready_release_cycle", 64'(axi_slv_arready), 64'd0);
    @(negedge clk);
    chk("arready_release_plus1", 64'(axi_slv_arready), 64'd1);
    @(posedge clk);
    #1;
    rr_manual = 1'b0;

    // directed bursts
    do_ar(4'd5, BASE + 32'h10, 8'd3, 3'd2, AXI_BURST_INCR);  wait_done();
    do_ar(4'd6, BASE + 32'h38, 8'd3, 3'd2, AXI_BURST_WRAP);  wait_done();
    do_ar(4'd7, BASE + 32'h08, 8'd2, 3'd2, AXI_BURST_FIXED); wait_done();
    do_ar(4'd2, BASE + 32'h13, 8'd2, 3'd0, 2'b11);           wait_done();

    // rready held low on beat 1
    rr_manual      = 1'b1;
    axi_slv_rready = 1'b0;
    do_ar(4'd10, BASE + 32'h100, 8'd3, 3'd2, AXI_BURST_INCR);
    for (int k = 0; k < 5; k++) begin
      if (exp_q.size() > 0) begin
        chk("stall_rvalid",  64'(axi_slv_rvalid),  64'd1);
        chk("stall_rdata",   64'(axi_slv_rdata),   64'(exp_q[0][31:0]));
        chk("stall_rlast",   64'(axi_slv_rlast),   64'(exp_q[0][32]));
        chk("stall_arready", 64'(axi_slv_arready), 64'd0);
        chk("stall_mem_en",  64'(mem_rd_en),       64'd0);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    axi_slv_rready = 1'b1;
    rr_manual      = 1'b0;
    wait_done();

    // longest burst: beat counter must reach 255 without wrapping
    do_ar(4'd1, BASE + 32'h400, 8'd255, 3'd2, AXI_BURST_INCR); wait_done();

    // random bursts
    for (int n = 0; n < 30; n++) begin
      b = 2'($urandom_range(0, 3));
      s = 3'($urandom_range(0, 2));
      if (b == AXI_BURST_WRAP) begin
        l = wrap_lens[$urandom_range(0, 3)];
        a = BASE + 32'($urandom_range(0, 3000)) * 4;
      end else begin
        l = 8'($urandom_range(0, 15));
        a = BASE + 32'($urandom_range(0, 3000)) * 4 + 32'($urandom_range(0, 3));
      end
      do_ar(4'($urandom), a, l, s, b);
      wait_done();
    end

`ifdef AXI_SLV_RD_ERR_CHK_EN
    do_ar(4'd4, BASE + (32'd4 << MAW) - 32'd4, 8'd1, 3'd2, AXI_BURST_INCR); wait_done();
    do_ar(4'd8, BASE + 32'h20, 8'd1, 3'd3, AXI_BURST_FIXED);               wait_done();
    do_ar(4'd9, BASE + 32'h40, 8'd2, 3'd2, AXI_BURST_WRAP);                wait_done();
`endif

    // reset pulse during beat 2 of a len=7 burst
    rr_manual      = 1'b1;
    axi_slv_rready = 1'b1;
    do_ar(4'd9, BASE + 32'h200, 8'd7, 3'd2, AXI_BURST_INCR);
    @(posedge clk);
    #1;
    axi_slv_rready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (axi_slv_rvalid) break;
    end
    chk("rstmid_beat2_valid", 64'(axi_slv_rvalid), 64'd1);
    chk("rstmid_beats_left",  64'(exp_q.size()),   64'd7);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rstmid");
    exp_q.delete();
    exp_addr_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_arready_release", 64'(axi_slv_arready), 64'd0);
    @(negedge clk);
    chk("rstmid_arready_plus1",   64'(axi_slv_arready), 64'd1);
    axi_slv_rready = 1'b1;
    do_ar(4'd3, BASE + 32'h40, 8'd0, 3'd2, AXI_BURST_INCR);
    wait_done();
    rr_manual = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
